// File: rtl/conv_load_sequencer.sv
// Host-to-accelerator load sequencer: streams feature then weight bytes, waits for settle, returns the result.
// Optional running byte checksum when LOAD_SEQ_CHECKSUM_EN is defined; otherwise checksum is tied to zero.
module conv_load_sequencer #(
   parameter int DATA_BYTES    = 64,
   parameter int WEIGHT_BYTES  = 54,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   output logic       mode,
   output logic [7:0] din,
   output logic       ram_en,
   input  logic [7:0] acc_dout,
   input  logic       acc_flag,
   output logic       res_valid,
   output logic [7:0] res_data,
   output logic       res_flag,
   input  logic       res_ready,
   output logic       busy,
   output logic [7:0] checksum
);

   localparam int MAX_A = (DATA_BYTES > WEIGHT_BYTES) ? DATA_BYTES : WEIGHT_BYTES;
   localparam int MAX_N = (MAX_A > SETTLE_CYCLES + 1) ? MAX_A : SETTLE_CYCLES + 1;
   localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   localparam logic [CW-1:0] DATA_LAST   = CW'(DATA_BYTES - 1);
   localparam logic [CW-1:0] WEIGHT_LAST = CW'(WEIGHT_BYTES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_DATA,
      LOAD_WEIGHT,
      SETTLE,
      RESULT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mode_q, mode_d;
   logic [7:0]    din_q, din_d;
   logic          ram_en_q, ram_en_d;
   logic          res_valid_q, res_valid_d;
   logic [7:0]    res_data_q, res_data_d;
   logic          res_flag_q, res_flag_d;
   logic          beat;

   assign s_ready = (state_q == LOAD_DATA) || (state_q == LOAD_WEIGHT);
   assign busy    = (state_q != IDLE);
   assign beat    = s_valid && s_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      din_d       = din_q;
      ram_en_d    = beat;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_flag_d  = res_flag_q;

      // mode only moves together with a write strobe
      if (beat) begin
         din_d  = s_data;
         mode_d = (state_q == LOAD_WEIGHT);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD_DATA;
               cnt_d   = '0;
            end
         end
         LOAD_DATA: begin
            if (beat) begin
               if (cnt_q == DATA_LAST) begin
                  state_d = LOAD_WEIGHT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         LOAD_WEIGHT: begin
            if (beat) begin
               if (cnt_q == WEIGHT_LAST) begin
                  state_d = SETTLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         SETTLE: begin
            // first SETTLE cycle carries the final strobe, then SETTLE_CYCLES more
            if (cnt_q == SETTLE_LAST) begin
               state_d     = RESULT;
               cnt_d       = '0;
               res_valid_d = 1'b1;
               res_data_d  = acc_dout;
               res_flag_d  = acc_flag;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESULT: begin
            if (res_ready) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         din_q       <= 8'h00;
         ram_en_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= 8'h00;
         res_flag_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         din_q       <= din_d;
         ram_en_q    <= ram_en_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_flag_q  <= res_flag_d;
      end
   end

   assign mode      = mode_q;
   assign din       = din_q;
   assign ram_en    = ram_en_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_flag  = res_flag_q;

`ifdef LOAD_SEQ_CHECKSUM_EN
   logic [7:0] ck_q, ck_d;

   always_comb begin
      ck_d = ck_q;
      if (state_q == IDLE && start) begin
         ck_d = 8'h00;
      end else if (beat) begin
         ck_d = ck_q + s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ck_q <= 8'h00;
      end else begin
         ck_q <= ck_d;
      end
   end

   assign checksum = ck_q;
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_conv_load_sequencer.sv
// Directed bench for conv_load_sequencer: table of full load/infer sequences plus reset corner cases.
module tb_conv_load_sequencer;

   localparam int DB    = 64;
   localparam int WB    = 54;
   localparam int SC    = 2;
   localparam int TOTAL = DB + WB;
`ifdef LOAD_SEQ_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, start, s_valid, s_ready;
   logic [7:0] s_data, din, acc_dout, res_data, checksum;
   logic       mode, ram_en, acc_flag, res_valid, res_flag, res_ready, busy;

   int n_chk  = 0;
   int n_fail = 0;
   logic exp_mode;

   conv_load_sequencer #(.DATA_BYTES(DB), .WEIGHT_BYTES(WB), .SETTLE_CYCLES(SC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .mode(mode), .din(din), .ram_en(ram_en),
      .acc_dout(acc_dout), .acc_flag(acc_flag),
      .res_valid(res_valid), .res_data(res_data), .res_flag(res_flag),
      .res_ready(res_ready), .busy(busy), .checksum(checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         gapped;
      bit         const3;
      bit         start_noise;
      logic [7:0] acc_d;
      bit         acc_f;
      int         hold;
      logic [7:0] exp_data;
      bit         exp_flag;
      logic [7:0] exp_ck;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_seq(input vec_t v);
      int         idx = 0;
      int         cyc = 0;
      int         err = 0;
      int         ram_cnt = 0;
      int         lat;
      bit         prev_beat = 1'b0;
      logic [7:0] prev_byte = 8'h00;
      acc_dout = v.acc_d;
      acc_flag = v.acc_f;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("s_ready_load", 32'(s_ready), 32'd1);
      forever begin
         if (ram_en !== prev_beat) err++;
         if (ram_en === 1'b1) ram_cnt++;
         if (prev_beat && din !== prev_byte) err++;
         if (mode !== exp_mode) err++;
         if (idx == TOTAL && !prev_beat) break;
         if (cyc > 600) begin
            err++;
            break;
         end
         if (idx < TOTAL) begin
            if (s_ready !== 1'b1) err++;
            s_valid = v.gapped ? (cyc % 2 == 0) : 1'b1;
            s_data  = v.const3 ? 8'h03 : 8'(idx);
         end else begin
            s_valid = 1'b0;
         end
         start     = v.start_noise && (cyc % 7 == 3);
         prev_beat = s_valid && (idx < TOTAL);
         if (prev_beat) begin
            prev_byte = s_data;
            exp_mode  = (idx >= DB);
            idx++;
         end
         cyc++;
         @(negedge clk);
      end
      start   = 1'b0;
      s_valid = 1'b0;
      chk("load_stream_errors", 32'(err), 32'd0);
      chk("ram_en_pulse_count", 32'(ram_cnt), 32'(TOTAL));
      chk("s_ready_settle", 32'(s_ready), 32'd0);
      lat = 1;
      while (res_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("res_valid_latency", 32'(lat), 32'(SC + 1));
      chk("res_data", 32'(res_data), 32'(v.exp_data));
      chk("res_flag", 32'(res_flag), 32'(v.exp_flag));
      acc_dout = 8'h00;
      acc_flag = ~v.acc_f;
      repeat (v.hold) @(negedge clk);
      chk("res_data_frozen", 32'(res_data), 32'(v.exp_data));
      chk("res_valid_held", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      start     = 1'b0;
      chk("res_valid_cleared", 32'(res_valid), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      @(negedge clk);
      chk("start_at_handshake_ignored", 32'(busy), 32'd0);
      chk("checksum", 32'(checksum), 32'(CK_EN ? v.exp_ck : 8'h00));
   endtask

   initial begin
      vec_t vecs[3];
      // bytes 0..117 sum to 6903 -> 0xF7; 118 x 3 = 354 -> 0x62
      vecs[0] = '{gapped: 1'b0, const3: 1'b0, start_noise: 1'b0, acc_d: 8'h5A, acc_f: 1'b1,
                  hold: 5, exp_data: 8'h5A, exp_flag: 1'b1, exp_ck: 8'hF7};
      vecs[1] = '{gapped: 1'b1, const3: 1'b1, start_noise: 1'b1, acc_d: 8'hA5, acc_f: 1'b0,
                  hold: 0, exp_data: 8'hA5, exp_flag: 1'b0, exp_ck: 8'h62};
      vecs[2] = '{gapped: 1'b0, const3: 1'b1, start_noise: 1'b1, acc_d: 8'hFF, acc_f: 1'b1,
                  hold: 2, exp_data: 8'hFF, exp_flag: 1'b1, exp_ck: 8'h62};

      rst_n = 1'b0; start = 1'b0; s_valid = 1'b1; s_data = 8'hC3;
      acc_dout = 8'h00; acc_flag = 1'b0; res_ready = 1'b0;
      exp_mode = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_s_ready", 32'(s_ready), 32'd0);
      chk("reset_ram_en", 32'(ram_en), 32'd0);
      chk("reset_mode", 32'(mode), 32'd0);
      chk("reset_res_valid", 32'(res_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_checksum", 32'(checksum), 32'd0);
      rst_n = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      chk("idle_s_ready", 32'(s_ready), 32'd0);

      for (int i = 0; i < 3; i++) run_seq(vecs[i]);

      // abandon a partial load with reset, then a fresh run must need all bytes again
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i);
         @(negedge clk);
      end
      s_valid = 1'b0;
      rst_n   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_mode = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_s_ready", 32'(s_ready), 32'd0);
      chk("midrst_ram_en", 32'(ram_en), 32'd0);
      chk("midrst_mode", 32'(mode), 32'd0);
      chk("midrst_checksum", 32'(checksum), 32'd0);
      @(negedge clk);
      run_seq(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_load_sequencer.md
Name: conv_load_sequencer

Overview:
- Host-side feeder for the CNN accelerator's byte-wide load interface (mode / din / ram_en).
- Accepts a valid/ready byte stream from the host and writes DATA_BYTES feature bytes with mode=0, then WEIGHT_BYTES weight bytes with mode=1.
- After loading, waits for the combinational conv/pool/FC path to settle, then captures the accelerator's 8-bit result and returns it over a valid/ready result port.
- Sits between the host/DMA and the accelerator top.

Parameters:
- DATA_BYTES, 64, feature-map bytes per inference (8x8x1).
- WEIGHT_BYTES, 54, weight bytes per inference (3x3x3x2).
- SETTLE_CYCLES, 2, wait cycles after the last ram_en beat before sampling acc_dout; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a load/infer sequence; honoured only in IDLE
- s_valid  in  1  host byte valid
- s_data  in  8  host byte
- s_ready  out  1  sequencer can accept a byte
- mode  out  8→1  accelerator select: 0 = data RAM, 1 = weight RAM (1 bit)
- din  out  8  accelerator write byte
- ram_en  out  1  accelerator write strobe, one cycle per byte
- acc_dout  in  8  accelerator result (dout)
- acc_flag  in  1  accelerator out_data_flag
- res_valid  out  1  result held and valid
- res_data  out  8  captured result
- res_flag  out  1  captured acc_flag
- res_ready  in  1  host accepts result
- busy  out  1  high in every state except IDLE
- checksum  out  8  see Optional Feature

Behaviour:
- Clocking and reset:
  - All state changes on the clk rising edge.
  - When rst_n=0 at an edge: state=IDLE, counters=0, mode=0, din=0, ram_en=0, res_valid=0, res_data=0, res_flag=0, checksum=0.
  - s_ready=0 and busy=0 from reset.
  - Reset mid-sequence abandons the sequence; a partial load is not resumed.
- FSM states: IDLE, LOAD_DATA, LOAD_WEIGHT, SETTLE, RESULT.
- IDLE:
  - s_ready=0.
  - start=1 → LOAD_DATA with byte counter=0.
- LOAD_DATA / LOAD_WEIGHT:
  - s_ready=1 (combinational from state).
  - On a beat (s_valid & s_ready), the next edge sets din<=s_data, ram_en<=1, and mode<=0 in LOAD_DATA or mode<=1 in LOAD_WEIGHT.
  - No beat → ram_en<=0; din and mode hold.
  - Latency host beat → ram_en is exactly 1 cycle. Back-to-back beats give consecutive ram_en cycles.
  - Counter increments per beat.
  - Beat with counter==DATA_BYTES-1 in LOAD_DATA → LOAD_WEIGHT, counter=0.
  - Beat with counter==WEIGHT_BYTES-1 in LOAD_WEIGHT → SETTLE, counter=0.
- SETTLE:
  - s_ready=0.
  - The final ram_en pulse occurs in the first SETTLE cycle.
  - Counter counts SETTLE_CYCLES cycles after that pulse, then → RESULT.
  - On entry to RESULT: res_data<=acc_dout, res_flag<=acc_flag, res_valid<=1.
- RESULT:
  - res_data and res_flag are frozen while res_valid=1.
  - res_valid & res_ready at an edge → res_valid<=0, → IDLE.
  - Results are never overwritten or dropped.
- start outside IDLE is ignored (no queueing).
- A start in the same cycle as the RESULT handshake is ignored; the sequencer is in IDLE only from the next cycle.
- mode holds its last value between beats. Mode changes only coincident with a ram_en beat, so the accelerator never sees a mode change without a write.
- Counter width: $clog2 of max(DATA_BYTES, WEIGHT_BYTES, SETTLE_CYCLES+1); no wrap within a phase.

Optional Feature:
- Macro: LOAD_SEQ_CHECKSUM_EN.
- Defined:
  - checksum is an 8-bit modulo-256 sum of all DATA_BYTES+WEIGHT_BYTES accepted bytes of the current sequence.
  - Cleared to 0 on start acceptance, updated on each beat, held through RESULT and IDLE until the next start.
- Undefined: checksum is tied to 8'h00 and no adder logic is generated.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with s_valid=1 → s_ready=0, ram_en=0, mode=0, res_valid=0, busy=0.
- Full load with s_valid always 1: start, stream bytes 0..117 →
  - ram_en high for exactly 118 consecutive cycles, starting 1 cycle after the first beat.
  - mode=0 for bytes 0..63 and mode=1 for bytes 64..117.
  - din mirrors each byte one cycle late.
- Gapped stream: s_valid toggles 1,0,1,0 → ram_en pulses only on accepted beats; byte count still 64+54; mode switch coincides with beat 64.
- Result capture: acc_dout=8'h5A, acc_flag=1 during SETTLE →
  - res_valid rises SETTLE_CYCLES+1 cycles after the last ram_en; res_data=8'h5A, res_flag=1.
  - With res_ready held 0 for 5 cycles and acc_dout changed to 8'h00, res_data stays 8'h5A.
  - res_ready=1 → IDLE the next cycle.
- Ignored start / mid-reset: start pulses during LOAD_DATA have no effect. rst_n=0 after 30 bytes → IDLE; a fresh start then requires a full 64+54 bytes.
- LOAD_SEQ_CHECKSUM_EN: all 118 bytes = 8'h03 → checksum=8'h62 (354 mod 256). Without the macro, checksum=8'h00.
